// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and the request arbiter around it.
package alu_pkg;

  localparam int unsigned ALU_W = 32;

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_AND = 5'd2;
  localparam logic [4:0] OP_OR  = 5'd3;
  localparam logic [4:0] OP_XOR = 5'd4;
  localparam logic [4:0] OP_SLL = 5'd5;
  localparam logic [4:0] OP_SRL = 5'd6;
  localparam logic [4:0] OP_MAX = 5'd6;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StResp = 2'd2
  } arb_state_e;

  // Opcodes above the last defined one are rejected rather than executed.
  function automatic logic op_illegal(input logic [4:0] op);
    return op > OP_MAX;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU: operands A/B, 5-bit control, result Y.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned W = ALU_W
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [4:0]   i_ctrl,
  output logic [W-1:0] o_y
);

  // Decode the control word into one of the seven operations.
  always_comb begin
    o_y = '0;
    unique case (i_ctrl)
      OP_ADD:  o_y = i_a + i_b;
      OP_SUB:  o_y = i_a - i_b;
      OP_AND:  o_y = i_a & i_b;
      OP_OR:   o_y = i_a | i_b;
      OP_XOR:  o_y = i_a ^ i_b;
      OP_SLL:  o_y = i_a << i_b[4:0];
      OP_SRL:  o_y = i_a >> i_b[4:0];
      default: o_y = '0;
    endcase
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin priority search: first valid index at or above the pointer, with wrap.
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_valid,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [IW-1:0]   o_idx,
  output logic            o_any
);

  // Walk NREQ positions starting at the pointer; the first valid one wins.
  always_comb begin
    int unsigned j;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    j       = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      j = (int'(i_ptr) + k) % NREQ;
      if (!o_any && i_valid[j]) begin
        o_any      = 1'b1;
        o_grant[j] = 1'b1;
        o_idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one ALU between NREQ requesters: round-robin accept, one-cycle execute,
// registered response tagged with the requester index.
module alu_req_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = ALU_W,
  parameter int unsigned CW   = 16,
  localparam int unsigned IW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req_valid,
  output logic [NREQ-1:0] req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ*5-1:0] req_op,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [W-1:0]    rsp_y,
  output logic [IW-1:0]   rsp_id,
  output logic            rsp_err,
  output logic            busy,
  output logic [CW-1:0]   ops_done
);

  arb_state_e    r_state;
  logic [IW-1:0] r_ptr;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [4:0]    r_op;
  logic [IW-1:0] r_gid;
  logic          r_rsp_valid;
  logic [W-1:0]  r_rsp_y;
  logic [IW-1:0] r_rsp_id;
  logic          r_rsp_err;
  logic          r_busy;
  logic [CW-1:0] r_ops_done;

  logic [NREQ-1:0] w_grant;
  logic [IW-1:0]   w_gidx;
  logic            w_any;
  logic [W-1:0]    w_sel_a;
  logic [W-1:0]    w_sel_b;
  logic [4:0]      w_sel_op;
  logic [W-1:0]    w_alu_y;
  logic [IW-1:0]   w_ptr_nxt;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_arbiter (
    .i_valid (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_gidx),
    .o_any   (w_any)
  );

  alu #(
    .W (W)
  ) u_alu (
    .i_a    (r_a),
    .i_b    (r_b),
    .i_ctrl (r_op),
    .o_y    (w_alu_y)
  );

  // Steer the granted requester's operands onto the capture path.
  always_comb begin
    w_sel_a  = '0;
    w_sel_b  = '0;
    w_sel_op = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_sel_a  = req_a[i*W +: W];
        w_sel_b  = req_b[i*W +: W];
        w_sel_op = req_op[i*5 +: 5];
      end
    end
  end

  // Pointer moves just past the winner so every requester gets a turn.
  always_comb begin
    w_ptr_nxt = (w_gidx == IW'(NREQ - 1)) ? '0 : w_gidx + IW'(1);
  end

  // Control FSM with registered response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_ptr       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= '0;
      r_gid       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_y     <= '0;
      r_rsp_id    <= '0;
      r_rsp_err   <= 1'b0;
      r_busy      <= 1'b0;
      r_ops_done  <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_any) begin
            r_a     <= w_sel_a;
            r_b     <= w_sel_b;
            r_op    <= w_sel_op;
            r_gid   <= w_gidx;
            r_ptr   <= w_ptr_nxt;
            r_busy  <= 1'b1;
            r_state <= StExec;
          end
        end
        StExec: begin
          r_rsp_y     <= op_illegal(r_op) ? '0 : w_alu_y;
          r_rsp_id    <= r_gid;
          r_rsp_err   <= op_illegal(r_op);
          r_rsp_valid <= 1'b1;
          r_state     <= StResp;
        end
        StResp: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_ops_done  <= r_ops_done + CW'(1);
            r_busy      <= 1'b0;
            r_state     <= StIdle;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= StIdle;
        end
      endcase
    end
  end

  // Accept only in IDLE; held low while reset is asserted.
  always_comb begin
    req_ready = (rst_n && (r_state == StIdle)) ? w_grant : '0;
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_y     = r_rsp_y;
  assign rsp_id    = r_rsp_id;
  assign rsp_err   = r_rsp_err;
  assign busy      = r_busy;
  assign ops_done  = r_ops_done;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter.
module tb_alu_req_arbiter;
  import alu_pkg::*;

  localparam int NREQ = 4;
  localparam int W    = 32;
  localparam int CW   = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ*5-1:0] req_op;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [W-1:0]      rsp_y;
  logic [1:0]        rsp_id;
  logic              rsp_err;
  logic              busy;
  logic [CW-1:0]     ops_done;

  // Second instance with a 3-bit counter so the wrap is reachable quickly.
  logic [1:0]  w_req_valid;
  logic [1:0]  w_req_ready;
  logic [63:0] w_req_a;
  logic [63:0] w_req_b;
  logic [9:0]  w_req_op;
  logic        w_rsp_valid;
  logic        w_rsp_ready;
  logic [31:0] w_rsp_y;
  logic [0:0]  w_rsp_id;
  logic        w_rsp_err;
  logic        w_busy;
  logic [2:0]  w_ops;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_ops  = 0;

  always #5 clk = ~clk;

  alu_req_arbiter #(.NREQ(NREQ), .W(W), .CW(CW)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_y     (rsp_y),
    .rsp_id    (rsp_id),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .ops_done  (ops_done)
  );

  alu_req_arbiter #(.NREQ(2), .W(32), .CW(3)) u_dut_wrap (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (w_req_valid),
    .req_ready (w_req_ready),
    .req_a     (w_req_a),
    .req_b     (w_req_b),
    .req_op    (w_req_op),
    .rsp_valid (w_rsp_valid),
    .rsp_ready (w_rsp_ready),
    .rsp_y     (w_rsp_y),
    .rsp_id    (w_rsp_id),
    .rsp_err   (w_rsp_err),
    .busy      (w_busy),
    .ops_done  (w_ops)
  );

  task automatic apply_reset();
    @(negedge clk);
    req_valid   = '0;
    rsp_ready   = 1'b0;
    w_req_valid = '0;
    rst_n       = 1'b0;
    #2;
    rst_n   = 1'b1;
    exp_ops = 0;
  endtask

  // Issue one op from requester id and collect its response (no checking here).
  task automatic run_op(input int id, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] op, output logic [31:0] y, output logic [1:0] rid,
                        output logic err, output int rdy_wait, output int lat, output bit ok);
    ok = 1'b0; y = '0; rid = '0; err = 1'b0; lat = 0;
    @(negedge clk);
    req_a[id*W +: W] = a;
    req_b[id*W +: W] = b;
    req_op[id*5 +: 5] = op;
    req_valid = '0;
    req_valid[id] = 1'b1;
    rsp_ready = 1'b1;
    #1;
    rdy_wait = 0;
    while (req_ready[id] !== 1'b1 && rdy_wait < 20) begin
      @(negedge clk); #1; rdy_wait++;
    end
    if (rdy_wait >= 20) return;
    @(posedge clk); #1;
    req_valid = '0;
    while (rsp_valid !== 1'b1 && lat < 20) begin
      @(negedge clk); lat++;
    end
    if (lat >= 20) return;
    y = rsp_y; rid = rsp_id; err = rsp_err; ok = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    req_valid = '1;
    rsp_ready = 1'b0;
    rst_n     = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 4'b0000 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: req_ready=%b rsp_valid=%b busy=%b, need 0000/0/0",
               req_ready, rsp_valid, busy);
    end
    n_checks++;
    if (rsp_y !== 32'h0 || rsp_id !== 2'd0 || rsp_err !== 1'b0 || ops_done !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_data: y=%h id=%0d err=%b ops=%0d, need 0/0/0/0",
               rsp_y, rsp_id, rsp_err, ops_done);
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_first_grant: req_ready=%b, need 0001", req_ready);
    end
    req_valid = '0;
    exp_ops = 0;
  endtask

  task automatic test_add();
    logic [31:0] y; logic [1:0] rid; logic err; int rw, lat; bit ok;
    apply_reset();
    run_op(0, 32'd2, 32'd1, OP_ADD, y, rid, err, rw, lat, ok);
    exp_ops++;
    n_checks++;
    if (!ok || rw !== 0 || lat !== 2) begin
      n_fail++;
      $display("FAIL add_timing: ok=%0d ready_wait=%0d latency=%0d, need 1/0/2", ok, rw, lat);
    end
    n_checks++;
    if (y !== 32'd3 || rid !== 2'd0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL add_result: y=%h id=%0d err=%b, need 3/0/0", y, rid, err);
    end
    n_checks++;
    if (ops_done !== 16'(exp_ops)) begin
      n_fail++;
      $display("FAIL add_ops_done: got %0d need %0d", ops_done, exp_ops);
    end
  endtask

  task automatic test_op_sweep();
    logic [31:0] exp_y [9];
    logic [4:0]  ops [9];
    logic [31:0] bs [9];
    logic [31:0] y; logic [1:0] rid; logic err; int rw, lat; bit ok;
    exp_y = '{32'h12C, 32'hB4, 32'h30, 32'hFC, 32'hCC, 32'h0, 32'h0, 32'hF00, 32'hF};
    ops   = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SLL, OP_SRL};
    bs    = '{32'h3C, 32'h3C, 32'h3C, 32'h3C, 32'h3C, 32'h3C, 32'h3C, 32'h4, 32'h4};
    for (int i = 0; i < 9; i++) begin
      run_op(1, 32'hF0, bs[i], ops[i], y, rid, err, rw, lat, ok);
      exp_ops++;
      n_checks++;
      if (!ok || y !== exp_y[i] || rid !== 2'd1 || err !== 1'b0) begin
        n_fail++;
        $display("FAIL sweep_op%0d_b%h: ok=%0d y=%h id=%0d err=%b, need y=%h id=1 err=0",
                 ops[i], bs[i], ok, y, rid, err, exp_y[i]);
      end
    end
    n_checks++;
    if (ops_done !== 16'(exp_ops)) begin
      n_fail++;
      $display("FAIL sweep_ops_done: got %0d need %0d", ops_done, exp_ops);
    end
  endtask

  task automatic test_round_robin();
    int gnt_idx [8];
    int gnt_cyc [8];
    int rsp_ids [8];
    int exp_ids [6];
    int ng, nr;
    exp_ids = '{0, 1, 2, 3, 0, 1};
    ng = 0; nr = 0;
    apply_reset();
    req_valid = '1;
    rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && nr < 6; cyc++) begin
      #1;
      if (req_ready !== 4'b0000 && ng < 8) begin
        n_checks++;
        if (!$onehot(req_ready)) begin
          n_fail++;
          $display("FAIL rr_onehot: req_ready=%b, need one bit", req_ready);
        end
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) gnt_idx[ng] = i;
        gnt_cyc[ng] = cyc;
        ng++;
      end
      if (rsp_valid === 1'b1) begin
        rsp_ids[nr] = int'(rsp_id);
        nr++;
      end
      @(negedge clk);
    end
    req_valid = '0;
    n_checks++;
    if (nr != 6 || ng < 6) begin
      n_fail++;
      $display("FAIL rr_count: responses=%0d grants=%0d, need 6/6", nr, ng);
    end else begin
      for (int k = 0; k < 6; k++) begin
        n_checks++;
        if (rsp_ids[k] != exp_ids[k] || gnt_idx[k] != exp_ids[k]) begin
          n_fail++;
          $display("FAIL rr_order%0d: rsp_id=%0d grant=%0d, need %0d",
                   k, rsp_ids[k], gnt_idx[k], exp_ids[k]);
        end
        if (k > 0) begin
          n_checks++;
          if (gnt_cyc[k] - gnt_cyc[k-1] != 3) begin
            n_fail++;
            $display("FAIL rr_spacing%0d: gap=%0d cycles, need 3",
                     k, gnt_cyc[k] - gnt_cyc[k-1]);
          end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int n;
    apply_reset();
    @(negedge clk);
    req_a[2*W +: W] = 32'd7;
    req_b[2*W +: W] = 32'd3;
    req_op[2*5 +: 5] = OP_ADD;
    req_valid = 4'b0100;
    rsp_ready = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL bp_grant: req_ready=%b, need 0100", req_ready);
    end
    @(posedge clk); #1;
    req_valid = 4'b1011;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 10) begin
      @(negedge clk); n++;
    end
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_y !== 32'd10 || rsp_id !== 2'd2 || rsp_err !== 1'b0 ||
          req_ready !== 4'b0000 || ops_done !== 16'd0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_hold%0d: v=%b y=%h id=%0d err=%b rdy=%b ops=%0d busy=%b, need 1/a/2/0/0000/0/1",
                 c, rsp_valid, rsp_y, rsp_id, rsp_err, req_ready, ops_done, busy);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = '0;
    exp_ops = 1;
    n_checks++;
    if (rsp_valid !== 1'b0 || ops_done !== 16'(exp_ops) || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: v=%b ops=%0d busy=%b, need 0/%0d/0",
               rsp_valid, ops_done, busy, exp_ops);
    end
  endtask

  task automatic test_illegal();
    logic [31:0] y; logic [1:0] rid; logic err; int rw, lat; bit ok;
    run_op(3, 32'd5, 32'd5, 5'd9, y, rid, err, rw, lat, ok);
    exp_ops++;
    n_checks++;
    if (!ok || err !== 1'b1 || y !== 32'h0 || rid !== 2'd3) begin
      n_fail++;
      $display("FAIL illegal_op: ok=%0d err=%b y=%h id=%0d, need 1/1/0/3", ok, err, y, rid);
    end
    n_checks++;
    if (ops_done !== 16'(exp_ops)) begin
      n_fail++;
      $display("FAIL illegal_ops_done: got %0d need %0d", ops_done, exp_ops);
    end
    // Idle rsp_ready must not count anything.
    @(negedge clk);
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (ops_done !== 16'(exp_ops) || rsp_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_ready: ops=%0d v=%b busy=%b, need %0d/0/0",
               ops_done, rsp_valid, busy, exp_ops);
    end
  endtask

  task automatic test_async_reset();
    int n;
    @(negedge clk);
    req_valid = '1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL ar_exec_busy: busy=%b, need 1", busy);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || ops_done !== 16'd0 || req_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL ar_exec: v=%b busy=%b ops=%0d rdy=%b, need 0/0/0/0000",
               rsp_valid, busy, ops_done, req_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL ar_first_grant: req_ready=%b, need 0001", req_ready);
    end
    rsp_ready = 1'b0;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 10) begin
      @(negedge clk); n++;
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (n >= 10 || rsp_valid !== 1'b0 || rsp_y !== 32'h0 || rsp_id !== 2'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ar_resp: wait=%0d v=%b y=%h id=%0d busy=%b, need <10/0/0/0/0",
               n, rsp_valid, rsp_y, rsp_id, busy);
    end
    req_valid = '0;
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_wrap();
    int n;
    apply_reset();
    w_req_valid = 2'b01;
    for (int k = 0; k < 8; k++) begin
      n = 0;
      while (w_rsp_valid !== 1'b1 && n < 10) begin
        @(negedge clk); n++;
      end
      if (n >= 10) begin
        n_checks++;
        n_fail++;
        $display("FAIL wrap_timeout: response %0d never arrived", k);
        break;
      end
      @(negedge clk);
      if (k == 0 || k == 6 || k == 7) begin
        n_checks++;
        if (w_ops !== 3'((k + 1) % 8)) begin
          n_fail++;
          $display("FAIL wrap_count%0d: ops_done=%0d need %0d", k, w_ops, (k + 1) % 8);
        end
      end
    end
    w_req_valid = '0;
  endtask

  initial begin
    rst_n       = 1'b0;
    req_valid   = '0;
    req_a       = '0;
    req_b       = '0;
    req_op      = '0;
    rsp_ready   = 1'b0;
    w_req_valid = '0;
    w_req_a     = {32'd0, 32'd1};
    w_req_b     = {32'd0, 32'd1};
    w_req_op    = '0;
    w_rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    test_reset();
    test_add();
    test_op_sweep();
    test_round_robin();
    test_backpressure();
    test_illegal();
    test_async_reset();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_req_arbiter.md
Name: alu_req_arbiter

Overview:
- Shares one combinational 32-bit ALU (operands A, B, 5-bit control, result Y) between NREQ independent requesters.
- Each requester presents an operand/opcode request over a valid/ready handshake.
- A round-robin arbiter grants one request at a time, captures the ALU result in a register, and returns it on a single response channel tagged with the requester ID.
- Sits between the ALU datapath and the client blocks.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 32, operand/result width; must match the ALU.
- CW, 16, width of the completed-operation counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high.
- req_a  in  NREQ*W  operand A per requester; requester i owns bits [i*W +: W].
- req_b  in  NREQ*W  operand B per requester, same packing.
- req_op  in  NREQ*5  opcode per requester; requester i owns bits [i*5 +: 5].
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_y  out  W  captured ALU result.
- rsp_id  out  $clog2(NREQ)  index of the requester served.
- rsp_err  out  1  opcode was illegal (>6).
- busy  out  1  high whenever the FSM is not in IDLE.
- ops_done  out  CW  count of completed responses; wraps modulo 2^CW.

Behaviour:
- Reset (async, rst_n=0):
  - FSM to IDLE; rsp_valid=0, rsp_y=0, rsp_id=0, rsp_err=0, busy=0, ops_done=0.
  - RR pointer=0; req_ready=0. Any in-flight op is discarded.
- Opcodes (from shared package):
  - 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR.
  - 5 SLL (A << B[4:0]), 6 SRL (A >> B[4:0], logical).
  - ADD/SUB wrap modulo 2^W; no carry output.
- FSM IDLE:
  - Round-robin pick g = first i with req_valid[i], searching from ptr upward with wrap.
  - req_ready[g]=1 combinationally, all other bits 0.
  - On accept: latch a, b, op, g into operand registers; ptr <= (g+1) mod NREQ; go to EXEC.
  - No valid request: stay in IDLE, all req_ready=0.
- FSM EXEC (1 cycle):
  - Drive the ALU from the latched operands.
  - Register rsp_y <= Y, rsp_id <= latched g, rsp_err <= (op>6).
  - If op>6, rsp_y <= 0 and the ALU result is ignored.
  - Go to RESP.
- FSM RESP:
  - rsp_valid=1; rsp_y, rsp_id and rsp_err held stable until rsp_valid&&rsp_ready.
  - On handshake: ops_done++, rsp_valid drops next cycle, go to IDLE.
  - Illegal-op responses count toward ops_done.
- Latency and throughput:
  - Accept edge to rsp_valid = 2 cycles.
  - With rsp_ready tied high, peak throughput is one op per 3 cycles.
  - req_ready is 0 in EXEC and RESP, so no new request is accepted while one is in flight.
- Requester side: a requester may drop or change req_valid/operands before acceptance; there is no lock. Data is sampled only on its accept edge.
- Boundary cases:
  - All NREQ valid continuously → grants cycle strictly 0,1,…,NREQ-1,0.
  - A single requester is granted back-to-back.
  - ops_done wraps from 2^CW-1 to 0.
  - Reset asserted in EXEC or RESP → outputs go to reset values immediately (async); the response is lost.
  - rsp_ready high while rsp_valid=0 has no effect.
- Combinational paths: req_valid → req_ready is permitted. No path from rsp_ready to any output except through registers.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams OP_ADD..OP_SRL (5'd0..5'd6) and OP_MAX=6;
  - state encoding IDLE/EXEC/RESP (2-bit);
  - default W=32.
- Sub-module rr_arbiter (NREQ valid bits + pointer in, one-hot grant and index out) isolates the priority search.
- The existing ALU module is instantiated unmodified, not re-coded.

Test Plan:
- Reset and ADD: only requester 0 valid, A=2, B=1, op=0, rsp_ready=1 → req_ready[0]=1 same cycle; rsp_valid 2 cycles later with rsp_y=3, rsp_id=0, rsp_err=0; ops_done=1.
- Full op sweep: requester 1 with A=32'hF0, B=32'h3C, ops 0..6 in turn → rsp_y = 0x12C, 0xB4, 0x30, 0xFC, 0xCC, 0xF0<<28=0x0, 0xF0>>28=0x0. Repeat with B=4 for shifts → 0xF00, 0xF.
- Round robin: all 4 requesters valid, holding, rsp_ready=1 → rsp_id sequence 0,1,2,3,0,1; each request accepted exactly once per turn, 3 cycles apart.
- Backpressure: rsp_ready=0 for 5 cycles in RESP → rsp_valid, rsp_y, rsp_id stable; req_ready all 0; ops_done unchanged until rsp_ready rises.
- Illegal op: op=5'd9, A=5, B=5 → rsp_err=1, rsp_y=0, ops_done increments.
- Async reset mid-op: assert rst_n=0 during EXEC → rsp_valid=0, busy=0, ops_done=0 before the next clock edge. After release, the first grant goes to requester 0 when all are valid.
